// File: rtl/pbvi_pkg.sv
// pbvi_pkg: shared PBVI constants, element/vector types and the dot-product helper
package pbvi_pkg;
   localparam int NUM_ACTION = 3;
   localparam int NUM_BELIEF = 16;
   localparam int NUM_STATE  = 2;
   localparam int DATA_W     = 16;
   localparam int DOT_W      = 2 * DATA_W + 1;
   localparam int ACT_W      = NUM_ACTION > 1 ? $clog2(NUM_ACTION) : 1;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [DOT_W-1:0] dot_t;
   typedef logic [ACT_W-1:0] action_t;
   typedef data_t [NUM_STATE-1:0] vec_t;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   function automatic dot_t dot_product(input vec_t g, input vec_t b);
      dot_t d = '0;
      for (int s = 0; s < NUM_STATE; s++) d += dot_t'(g[s]) * dot_t'(b[s]);
      return d;
   endfunction
endpackage

// File: rtl/step3_if.sv
// step3_if: start/data/result bundle between step2 (master) and step3 (slave)
interface step3_if;
   import pbvi_pkg::*;
   logic    en;
   vec_t    gamma_action_belief [NUM_ACTION][NUM_BELIEF];
   vec_t    point_belief [NUM_BELIEF];
   logic    busy;
   logic    en_step4;
   vec_t    alpha_out [NUM_BELIEF];
   action_t best_action [NUM_BELIEF];
   dot_t    belief_value [NUM_BELIEF];
   modport master (
      output en, gamma_action_belief, point_belief,
      input  busy, en_step4, alpha_out, best_action, belief_value
   );
   modport slave (
      input  en, gamma_action_belief, point_belief,
      output busy, en_step4, alpha_out, best_action, belief_value
   );
endinterface

// File: rtl/pbvi_argmax.sv
// pbvi_argmax: combinational argmax over per-action dot products, ties go to the lowest index
module pbvi_argmax
   import pbvi_pkg::*;
(
   input  dot_t    dot [NUM_ACTION],
   output action_t idx,
   output dot_t    max
);
   always_comb begin
      idx = '0;
      max = dot[0];
      for (int a = 1; a < NUM_ACTION; a++) begin
         if (dot[a] > max) begin
            idx = action_t'(a);
            max = dot[a];
         end
      end
   end
endmodule

// File: rtl/step3.sv
// step3: snapshots step2's candidate vectors and belief points, then picks the
// best action per belief through a dot-product / argmax pipeline.
module step3
   import pbvi_pkg::*;
(
   input logic     clk,
   input logic     rst,
   step3_if.slave  bus
);
   localparam int BEL_W = $clog2(NUM_BELIEF);
   localparam int CNT_W = $clog2(NUM_BELIEF + 2);
   typedef logic [BEL_W-1:0] bel_t;
   typedef logic [CNT_W-1:0] cnt_t;

   state_e  state_q, state_d;
   cnt_t    cnt_q, cnt_d;
   vec_t    g_q [NUM_ACTION][NUM_BELIEF];
   vec_t    g_d [NUM_ACTION][NUM_BELIEF];
   vec_t    b_q [NUM_BELIEF];
   vec_t    b_d [NUM_BELIEF];
   dot_t    dot_q [NUM_ACTION];
   dot_t    dot_d [NUM_ACTION];
   bel_t    s1_idx_q, s1_idx_d;
   logic    s1_vld_q, s1_vld_d;
   vec_t    alpha_q [NUM_BELIEF];
   vec_t    alpha_d [NUM_BELIEF];
   action_t best_q [NUM_BELIEF];
   action_t best_d [NUM_BELIEF];
   dot_t    value_q [NUM_BELIEF];
   dot_t    value_d [NUM_BELIEF];
   action_t am_idx;
   dot_t    am_max;
   bel_t    bel;

   assign bel = cnt_q[BEL_W-1:0];

   pbvi_argmax u_argmax (.dot(dot_q), .idx(am_idx), .max(am_max));

   // The counter runs two past the last belief so the DONE cycle lands after the final write has settled.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      g_d      = g_q;
      b_d      = b_q;
      dot_d    = dot_q;
      s1_idx_d = s1_idx_q;
      s1_vld_d = 1'b0;
      alpha_d  = alpha_q;
      best_d   = best_q;
      value_d  = value_q;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               g_d     = bus.gamma_action_belief;
               b_d     = bus.point_belief;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q < cnt_t'(NUM_BELIEF)) begin
               for (int a = 0; a < NUM_ACTION; a++) dot_d[a] = dot_product(g_q[a][bel], b_q[bel]);
               s1_idx_d = bel;
               s1_vld_d = 1'b1;
            end
            if (s1_vld_q) begin
               best_d[s1_idx_q]  = am_idx;
               value_d[s1_idx_q] = am_max;
               alpha_d[s1_idx_q] = g_q[am_idx][s1_idx_q];
            end
            state_d = cnt_q == cnt_t'(NUM_BELIEF + 1) ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         g_q      <= '{default: '0};
         b_q      <= '{default: '0};
         dot_q    <= '{default: '0};
         s1_idx_q <= '0;
         s1_vld_q <= 1'b0;
         alpha_q  <= '{default: '0};
         best_q   <= '{default: '0};
         value_q  <= '{default: '0};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         g_q      <= g_d;
         b_q      <= b_d;
         dot_q    <= dot_d;
         s1_idx_q <= s1_idx_d;
         s1_vld_q <= s1_vld_d;
         alpha_q  <= alpha_d;
         best_q   <= best_d;
         value_q  <= value_d;
      end
   end

   assign bus.busy         = state_q != IDLE;
   assign bus.en_step4     = state_q == DONE;
   assign bus.alpha_out    = alpha_q;
   assign bus.best_action  = best_q;
   assign bus.belief_value = value_q;
endmodule

// File: tb/tb_step3.sv
// tb_step3: directed and randomized checks of step3 against a plain-arithmetic argmax model
module tb_step3;
   import pbvi_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   step3_if bus ();
   step3 dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;
   int unsigned gm [NUM_ACTION][NUM_BELIEF][NUM_STATE];
   int unsigned bm [NUM_BELIEF][NUM_STATE];
   longint unsigned exp_val [NUM_BELIEF];
   int exp_act [NUM_BELIEF];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand(input int unsigned hi);
      for (int i = 0; i < NUM_BELIEF; i++)
         for (int s = 0; s < NUM_STATE; s++) begin
            bm[i][s] = $urandom_range(hi, 0);
            for (int a = 0; a < NUM_ACTION; a++) gm[a][i][s] = $urandom_range(hi, 0);
         end
   endtask

   task automatic load();
      for (int i = 0; i < NUM_BELIEF; i++)
         for (int s = 0; s < NUM_STATE; s++) begin
            bus.point_belief[i][s] = data_t'(bm[i][s]);
            for (int a = 0; a < NUM_ACTION; a++) bus.gamma_action_belief[a][i][s] = data_t'(gm[a][i][s]);
         end
   endtask

   task automatic scramble_bus();
      for (int i = 0; i < NUM_BELIEF; i++)
         for (int s = 0; s < NUM_STATE; s++) begin
            bus.point_belief[i][s] = data_t'($urandom);
            for (int a = 0; a < NUM_ACTION; a++) bus.gamma_action_belief[a][i][s] = data_t'($urandom);
         end
   endtask

   // Highest value first, then the first action reaching it.
   task automatic model();
      longint unsigned d [NUM_ACTION];
      for (int i = 0; i < NUM_BELIEF; i++) begin
         longint unsigned mx = 0;
         for (int a = 0; a < NUM_ACTION; a++) begin
            d[a] = 0;
            for (int s = 0; s < NUM_STATE; s++) d[a] += longint'(gm[a][i][s]) * longint'(bm[i][s]);
            if (d[a] > mx) mx = d[a];
         end
         exp_val[i] = mx;
         exp_act[i] = -1;
         for (int a = NUM_ACTION - 1; a >= 0; a--) if (d[a] == mx) exp_act[i] = a;
      end
   endtask

   task automatic check_results(input string tag);
      for (int i = 0; i < NUM_BELIEF; i++) begin
         int b = exp_act[i];
         chk($sformatf("%s best[%0d]", tag, i), 64'(bus.best_action[i]), 64'(b));
         chk($sformatf("%s value[%0d]", tag, i), 64'(bus.belief_value[i]), exp_val[i]);
         chk($sformatf("%s alpha[%0d]", tag, i), 64'(bus.alpha_out[i]),
             (64'(gm[b][i][1]) << 16) | 64'(gm[b][i][0]));
      end
   endtask

   task automatic check_zero(input string tag);
      chk($sformatf("%s busy", tag), 64'(bus.busy), 64'd0);
      chk($sformatf("%s en_step4", tag), 64'(bus.en_step4), 64'd0);
      for (int i = 0; i < NUM_BELIEF; i++) begin
         chk($sformatf("%s best[%0d]", tag, i), 64'(bus.best_action[i]), 64'd0);
         chk($sformatf("%s value[%0d]", tag, i), 64'(bus.belief_value[i]), 64'd0);
         chk($sformatf("%s alpha[%0d]", tag, i), 64'(bus.alpha_out[i]), 64'd0);
      end
   endtask

   task automatic run(input bit disturb, input string tag);
      int rise = -1;
      int pulses = 0;
      load();
      model();
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      chk($sformatf("%s busy_start", tag), 64'(bus.busy), 64'd1);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.en_step4) begin
            pulses++;
            if (rise < 0) rise = k;
         end
         if (disturb) begin
            if (k == 1) scramble_bus();
            bus.en = k == 4;
         end
      end
      chk($sformatf("%s rise_edge", tag), 64'(rise), 64'd18);
      chk($sformatf("%s pulses", tag), 64'(pulses), 64'd1);
      chk($sformatf("%s busy_end", tag), 64'(bus.busy), 64'd0);
      check_results(tag);
   endtask

   initial begin
      int pulses;
      bus.en = 1'b0;
      fill_rand(65535);
      load();
      rst = 1'b1;
      bus.en = 1'b1;
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;
      bus.en = 1'b0;
      tick();

      for (int i = 0; i < NUM_BELIEF; i++) begin
         bm[i][0] = 1;
         bm[i][1] = 0;
         for (int a = 0; a < NUM_ACTION; a++) begin
            gm[a][i][0] = 10 * a + 1;
            gm[a][i][1] = 5;
         end
      end
      run(1'b0, "distinct");
      chk("distinct const best", 64'(bus.best_action[7]), 64'd2);
      chk("distinct const value", 64'(bus.belief_value[7]), 64'd21);
      chk("distinct const alpha", 64'(bus.alpha_out[7]), 64'h0005_0015);

      for (int i = 0; i < NUM_BELIEF; i++) begin
         bm[i][0] = 2;
         bm[i][1] = 2;
         for (int a = 0; a < NUM_ACTION; a++) begin
            gm[a][i][0] = 3;
            gm[a][i][1] = 4;
         end
      end
      run(1'b0, "tie");
      chk("tie const best", 64'(bus.best_action[15]), 64'd0);
      chk("tie const value", 64'(bus.belief_value[15]), 64'd14);

      fill_rand(0);
      for (int i = 0; i < NUM_BELIEF; i++)
         for (int s = 0; s < NUM_STATE; s++) begin
            bm[i][s] = 16'hFFFF;
            for (int a = 0; a < NUM_ACTION; a++) gm[a][i][s] = 16'hFFFF;
         end
      run(1'b0, "width");
      chk("width const value", 64'(bus.belief_value[3]), 64'h1_FFFC_0002);
      chk("width const best", 64'(bus.best_action[3]), 64'd0);

      fill_rand(7);
      run(1'b0, "rand_small");
      fill_rand(65535);
      run(1'b0, "rand_full");
      fill_rand(3);
      run(1'b0, "rand_ties");

      fill_rand(65535);
      run(1'b1, "capture");

      fill_rand(65535);
      load();
      bus.en = 1'b1;
      tick();
      bus.en = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero("midrst");
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.en_step4) pulses++;
      end
      chk("midrst no_done", 64'(pulses), 64'd0);
      fill_rand(65535);
      run(1'b0, "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
